// File: rtl/aes_key_expand_if.sv
// Round-key delivery bus from the AES-128 key schedule to the round datapath.
// The master drives key/index/valid, and the slave returns ready.
interface aes_key_expand_if;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready;

    modport master (output round_key, output round_idx, output rk_valid, input rk_ready);
    modport slave  (input round_key, input round_idx, input rk_valid, output rk_ready);
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NR over a valid/ready bus.
// Define AES_KEY_STORE_EN to keep every round key in a readable store (ks_addr/ks_data).
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key_in,
    aes_key_expand_if.master rk,
    output logic             busy,
    output logic             done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]       ks_addr,
    output logic [127:0]     ks_data
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // Row 0 of the FIPS-197 table sits in the top element, so a byte b is looked up at ~b.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[~b];
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q;
    logic [3:0]   idx_q;
    logic [7:0]   rcon_q;
    logic         valid_c, load, advance;

    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    logic [127:0] next_key;

    assign w0  = key_q[127:96];
    assign w1  = key_q[95:64];
    assign w2  = key_q[63:32];
    assign w3  = key_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon_q, 24'h0};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (rk.rk_ready && idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The final round is accepted without advancing, so key and index stay visible after done.
    always_comb begin
        valid_c = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE: load = start;
            ST_RUN: begin
                valid_c = 1'b1;
                busy    = 1'b1;
                advance = rk.rk_ready && (idx_q != LAST_IDX);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            idx_q  <= '0;
            rcon_q <= 8'h01;
        end else if (load) begin
            key_q  <= key_in;
            idx_q  <= '0;
            rcon_q <= 8'h01;
        end else if (advance) begin
            key_q  <= next_key;
            idx_q  <= idx_q + 4'd1;
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
    end

    assign rk.round_key = key_q;
    assign rk.round_idx = idx_q;
    assign rk.rk_valid  = valid_c;

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [NR+1];
    logic         ks_we;

    assign ks_we = valid_c & rk.rk_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) store_q[i] <= '0;
            ks_data <= '0;
        end else begin
            if (ks_we) store_q[idx_q] <= key_q;
            ks_data <= (ks_addr <= LAST_IDX) ? store_q[ks_addr] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a GF(2^8)-derived reference schedule checked
// against directed FIPS-197 runs and randomized keys, backpressure and spurious starts.
module tb_aes_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   ks_addr;
    logic [127:0] ks_data;
`endif

    aes_key_expand_if rk_if ();

    aes_key_expand dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .key_in (key_in),
        .rk     (rk_if),
        .busy   (busy),
        .done   (done)
`ifdef AES_KEY_STORE_EN
        ,
        .ks_addr(ks_addr),
        .ks_data(ks_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]   sbox_tab   [0:255];
    logic [127:0] model_keys [0:10];
    logic [127:0] got        [0:10];

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) followed by the affine map.
    task automatic build_sbox;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h01;
            logic [7:0] xb = 8'(x);
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gf_mul(inv, xb);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_idle_zero(input string tag);
        checkOutput({tag, " key"},   rk_if.round_key, 128'd0);
        checkOutput({tag, " idx"},   128'(rk_if.round_idx), 128'd0);
        checkOutput({tag, " valid"}, 128'(rk_if.rk_valid), 128'd0);
        checkOutput({tag, " busy"},  128'(busy), 128'd0);
        checkOutput({tag, " done"},  128'(done), 128'd0);
    endtask

    // mode 0: full rate; 1: 3-cycle stall at idx4 plus foreign start at idx5;
    // 2: random ready and random starts. rst_at >= 0 aborts with reset at that index.
    task automatic applyStimulus(input logic [127:0] key, input int mode, input int rst_at,
                                 input string tag);
        int  idx = 0;
        int  cycles;
        int  stall = 0;
        bit  finished = 1'b0;
        bit  pulsed = 1'b0;
        bit  accept;
        compute_model(key);
        rk_if.rk_ready = 1'b0;
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (!finished && cycles < 200) begin
            checkOutput($sformatf("%s idx%0d valid", tag, idx), 128'(rk_if.rk_valid), 128'd1);
            checkOutput($sformatf("%s idx%0d busy", tag, idx), 128'(busy), 128'd1);
            checkOutput($sformatf("%s idx%0d done", tag, idx), 128'(done), 128'd0);
            checkOutput($sformatf("%s idx%0d index", tag, idx), 128'(rk_if.round_idx), 128'(idx));
            checkOutput($sformatf("%s idx%0d key", tag, idx), rk_if.round_key, model_keys[idx]);
            got[idx] = rk_if.round_key;
            if (rst_at == idx) begin
                rst = 1'b1;
                #1;
                check_idle_zero({tag, " async rst"});
                tick();
                check_idle_zero({tag, " held rst"});
                rst = 1'b0;
                tick();
                check_idle_zero({tag, " after rst"});
                return;
            end
            start = 1'b0;
            case (mode)
                1: begin
                    if (idx == 4 && stall < 3) begin
                        rk_if.rk_ready = 1'b0;
                        stall++;
                    end else begin
                        rk_if.rk_ready = 1'b1;
                    end
                    if (idx == 5 && !pulsed) begin
                        start  = 1'b1;
                        key_in = ~key;
                        pulsed = 1'b1;
                    end
                end
                2: begin
                    rk_if.rk_ready = 1'($urandom_range(0, 1));
                    start  = ($urandom_range(0, 3) == 0);
                    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                default: rk_if.rk_ready = 1'b1;
            endcase
            accept = rk_if.rk_ready;
            tick();
            cycles++;
            if (accept) begin
                if (idx == 10) finished = 1'b1;
                else idx++;
            end
        end
        checkOutput({tag, " completed in budget"}, 128'(finished), 128'd1);
        checkOutput({tag, " done pulse"}, 128'(done), 128'd1);
        checkOutput({tag, " valid at done"}, 128'(rk_if.rk_valid), 128'd0);
        checkOutput({tag, " busy at done"}, 128'(busy), 128'd0);
        if (mode == 0) checkOutput({tag, " start-to-done cycles"}, 128'(cycles), 128'd12);
        start = (mode == 2);
        tick();
        start = 1'b0;
        checkOutput({tag, " done cleared"}, 128'(done), 128'd0);
        checkOutput({tag, " idx held"}, 128'(rk_if.round_idx), 128'd10);
        checkOutput({tag, " key held"}, rk_if.round_key, model_keys[10]);
        tick();
        checkOutput({tag, " idle valid"}, 128'(rk_if.rk_valid), 128'd0);
        checkOutput({tag, " idle busy"}, 128'(busy), 128'd0);
    endtask

`ifdef AES_KEY_STORE_EN
    task automatic check_store(input string tag);
        for (int a = 0; a < 16; a++) begin
            ks_addr = 4'(a);
            tick();
            checkOutput($sformatf("%s ks%0d", tag, a), ks_data,
                        (a <= 10) ? model_keys[a] : 128'd0);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        key_in         = '0;
        rk_if.rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
        ks_addr        = '0;
`endif
        build_sbox();
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();
        tick();
        check_idle_zero("idle no start");

        applyStimulus(KEY_A1, 0, -1, "A1 full");
        checkOutput("A1 idx0 kat", got[0], KEY_A1);
        checkOutput("A1 idx1 kat", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("A1 idx10 kat", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_STORE_EN
        ks_addr = 4'd10;
        tick();
        checkOutput("A1 ks10 kat", ks_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        ks_addr = 4'd15;
        tick();
        checkOutput("A1 ks15 zero", ks_data, 128'd0);
        check_store("A1 store");
`endif

        applyStimulus(KEY_A1, 1, -1, "A1 stall");
        checkOutput("A1 stall idx4 kat", got[4], 128'hef44a541a8525b7fb671253bdb0bad00);
        checkOutput("A1 stall idx10 kat", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        applyStimulus(KEY_A1, 0, 7, "A1 reset");
        applyStimulus(KEY_A1, 0, -1, "A1 restart");
        checkOutput("A1 restart idx1 kat", got[1], 128'ha0fafe1788542cb123a339392a6c7605);

        applyStimulus(128'd0, 0, -1, "zero key");
        checkOutput("zero idx1 kat", got[1], 128'h62636363626363636263636362636363);
        checkOutput("zero idx10 kat", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int n = 0; n < 4; n++)
            applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()}, 2, -1,
                          $sformatf("rand%0d", n));
`ifdef AES_KEY_STORE_EN
        check_store("rand store");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Produces the 11 round keys (rounds 0..10) in order, one per accepted handshake.
- Sits directly upstream of the round datapath and feeds its AddRoundKey stage.
- Performs SubWord internally using the FIPS-197 forward S-box values, the same table as the codebase's S-box constant block.
- Output uses a valid/ready handshake so the round datapath can stall key delivery.

Parameters:
- NR, 10, number of rounds after round 0. Fixed at 10 for AES-128; other values unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin expansion of key_in; sampled only in IDLE.
- key_in  input  128  cipher key; bits [127:96] = w0, [31:0] = w3.
- round_key  output  128  current round key, same word ordering as key_in.
- round_idx  output  4  index (0..10) of round_key.
- rk_valid  output  1  round_key/round_idx valid.
- rk_ready  input  1  consumer accepts when rk_valid & rk_ready.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after round 10 is accepted.

Behaviour:
- Reset values, asynchronous on rst high:
  - round_key = 0, round_idx = 0, rk_valid = 0, busy = 0, done = 0.
  - rcon register = 8'h01, state = IDLE.
- States:
  - IDLE: start=1 → latch key_in into round_key, round_idx=0, rcon=01, rk_valid=1, busy=1 on the next edge; go RUN. start=0 → stay IDLE.
  - RUN, accept with round_idx<10:
    - round_key ← next key, round_idx+1, rcon ← xtime(rcon).
    - xtime: shift left 1; XOR 8'h1b if bit 7 was set. Sequence is 01,02,04,08,10,20,40,80,1b,36.
    - rk_valid stays high.
  - RUN, accept with round_idx=10: rk_valid=0, busy=0, done=1 on the next edge; go DONE.
  - DONE: done=0 next edge; go IDLE.
- Next-key function (combinational from registered key):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord {a,b,c,d} → {b,c,d,a}.
  - SubWord applies the S-box to each byte independently.
  - All XOR is 8-bit GF(2) with no carries.
- Latency:
  - start → round 0 valid: 1 cycle.
  - Each accept → next key valid on the following cycle. Full rate is one key per cycle when rk_ready is held high.
  - start → done with rk_ready=1: 12 cycles.
- Backpressure: while rk_valid=1 and rk_ready=0, round_key, round_idx and rcon hold exactly.
- start while busy or in DONE: ignored, no restart. key_in changes during expansion have no effect.
- rst mid-expansion: immediate return to reset values. No done pulse is produced.
- round_key and round_idx remain at their last values after done, until the next start.

Optional Feature:
- AES_KEY_STORE_EN defined:
  - Adds an internal 11×128 register file, written at round_idx on every accepted key.
  - Adds ports ks_addr (input, 4) and ks_data (output, 128). ks_data is registered with 1-cycle read latency.
  - ks_addr > 10 returns 0.
  - Contents reset to 0 and are overwritten by each new expansion. Used for decryption in reverse order.
- AES_KEY_STORE_EN undefined: no storage and no ks_* ports; behaviour is otherwise identical.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 →
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done 12 cycles after start.
- Same key, rk_ready low 3 cycles at idx4 → idx4 key (ef44a541a8525b7fb671253bdb0bad00) held stable for all 3 cycles; sequence then resumes with no skipped or duplicated round.
- start pulse at idx5 with a different key_in → ignored; remaining keys match the original key's schedule.
- rst asserted at idx7 → all outputs 0 immediately, no done pulse. A fresh start then restarts at idx0 with rcon=01.
- All-zero key → idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- AES_KEY_STORE_EN: after full expansion of the A.1 key, ks_addr=10 → ks_data = d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; ks_addr=15 → 0.
